// File: rtl/sipo_rx_ctrl.sv
// Serial-in/parallel-out frame controller: shifts qualified serial bits into words
// and presents each completed word through a valid/ready holding register.
module sipo_rx_ctrl #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Din,
  input  logic             Din_valid,
  input  logic             Start,
  input  logic             Stop,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_valid,
  input  logic             Dout_ready,
  output logic             Busy,
  output logic             Overrun,
  output logic [CW-1:0]    Bit_count
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_nxt, sr_shift;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] dout, dout_nxt;
  logic             dvld, dvld_nxt;
  logic             ovr, ovr_nxt;
  logic             last_bit;

  assign sr_shift = MSB_FIRST ? {sr[WIDTH-2:0], Din} : {Din, sr[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      dout  <= '0;
      dvld  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      dout  <= dout_nxt;
      dvld  <= dvld_nxt;
      ovr   <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    dout_nxt  = dout;
    dvld_nxt  = dvld;
    ovr_nxt   = ovr;

    // Delivery runs in both states so a pending word survives Stop.
    if (dvld && Dout_ready)
      dvld_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (Start && !Stop) begin
          state_nxt = SHIFT;
          sr_nxt    = '0;
          cnt_nxt   = '0;
          ovr_nxt   = 1'b0;
        end
      end
      SHIFT: begin
        if (Stop) begin
          state_nxt = IDLE;
          sr_nxt    = '0;
          cnt_nxt   = '0;
        end else if (Start) begin
          sr_nxt  = '0;
          cnt_nxt = '0;
          ovr_nxt = 1'b0;
        end else if (Din_valid) begin
          sr_nxt = sr_shift;
          if (last_bit) begin
            cnt_nxt = '0;
            // Holding register is free if empty or being drained on this edge.
            if (!dvld || Dout_ready) begin
              dout_nxt = sr_shift;
              dvld_nxt = 1'b1;
            end else begin
              ovr_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Dout       = dout;
  assign Dout_valid = dvld;
  assign Busy       = (state == SHIFT);
  assign Overrun    = ovr;
  assign Bit_count  = cnt;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl: MSB-first and LSB-first instances share stimulus.
module tb_sipo_rx_ctrl;

  localparam int W  = 4;
  localparam int CW = $clog2(W);

  logic          Clk = 1'b0;
  logic          Rst_n, Din, Din_valid, Start, Stop, Dout_ready;
  logic [W-1:0]  m_dout, l_dout;
  logic          m_vld, l_vld, m_busy, l_busy, m_ovr, l_ovr;
  logic [CW-1:0] m_cnt, l_cnt;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  sipo_rx_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .Clk(Clk), .Rst_n(Rst_n), .Din(Din), .Din_valid(Din_valid),
    .Start(Start), .Stop(Stop), .Dout(m_dout), .Dout_valid(m_vld),
    .Dout_ready(Dout_ready), .Busy(m_busy), .Overrun(m_ovr), .Bit_count(m_cnt)
  );

  sipo_rx_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .Clk(Clk), .Rst_n(Rst_n), .Din(Din), .Din_valid(Din_valid),
    .Start(Start), .Stop(Stop), .Dout(l_dout), .Dout_valid(l_vld),
    .Dout_ready(Dout_ready), .Busy(l_busy), .Overrun(l_ovr), .Bit_count(l_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Drive one valid bit for one edge; Din_valid is left high for streaming.
  task automatic bit_in(input logic b);
    Din = b;
    Din_valid = 1'b1;
    tick();
  endtask

  task automatic pulse_start;
    Din_valid = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b1; Din = 1'b0; Din_valid = 1'b0; Start = 1'b0; Stop = 1'b0;
    Dout_ready = 1'b0;
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_dout", m_dout, 0);
    chk("rst_vld", m_vld, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_ovr", m_ovr, 0);
    chk("rst_cnt", m_cnt, 0);
    tick(); tick();
    Rst_n = 1'b1;
    tick();
    chk("idle_busy", m_busy, 0);

    // Basic MSB-first word 1011
    Dout_ready = 1'b1;
    pulse_start();
    chk("t1_busy", m_busy, 1);
    chk("t1_cnt0", m_cnt, 0);
    bit_in(1'b1); chk("t1_cnt1", m_cnt, 1);
    bit_in(1'b0); chk("t1_cnt2", m_cnt, 2);
    bit_in(1'b1); chk("t1_cnt3", m_cnt, 3); chk("t1_vld_early", m_vld, 0);
    bit_in(1'b1); chk("t1_cnt_wrap", m_cnt, 0);
    chk("t1_dout", m_dout, 4'hB);
    chk("t1_vld", m_vld, 1);
    chk("t1_lsb_dout", l_dout, 4'hD);
    chk("t1_busy2", m_busy, 1);
    Din_valid = 1'b0;
    tick();
    chk("t1_vld_one_cycle", m_vld, 0);

    // Same bits with two-cycle gaps
    bit_in(1'b1); Din_valid = 1'b0; tick(); tick();
    chk("t2_hold1", l_cnt, 1);
    bit_in(1'b0); Din_valid = 1'b0; tick(); tick();
    chk("t2_hold2", l_cnt, 2);
    bit_in(1'b1); Din_valid = 1'b0; tick(); tick();
    chk("t2_hold3", l_cnt, 3);
    chk("t2_vld_early", l_vld, 0);
    bit_in(1'b1); Din_valid = 1'b0;
    chk("t2_lsb_dout", l_dout, 4'hD);
    chk("t2_lsb_vld", l_vld, 1);
    chk("t2_msb_dout", m_dout, 4'hB);
    tick();
    chk("t2_vld_clr", l_vld, 0);

    // Streaming A then 5 with the consumer stalled
    Dout_ready = 1'b0;
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
    chk("t3_dout_a", m_dout, 4'hA);
    chk("t3_vld_a", m_vld, 1);
    chk("t3_ovr_a", m_ovr, 0);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    Din_valid = 1'b0;
    chk("t3_dout_keep", m_dout, 4'hA);
    chk("t3_ovr", m_ovr, 1);
    chk("t3_vld_keep", m_vld, 1);
    Dout_ready = 1'b1;
    tick();
    chk("t3_vld_drain", m_vld, 0);
    chk("t3_ovr_sticky", m_ovr, 1);
    pulse_start();
    chk("t3_ovr_clr", m_ovr, 0);

    // Transfer and completion on the same edge
    Dout_ready = 1'b0;
    bit_in(1'b0); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    chk("t4_dout3", m_dout, 4'h3);
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    chk("t4_hold3", m_dout, 4'h3);
    Dout_ready = 1'b1;
    bit_in(1'b0);
    Din_valid = 1'b0;
    chk("t4_dout_c", m_dout, 4'hC);
    chk("t4_vld", m_vld, 1);
    chk("t4_ovr", m_ovr, 0);
    tick();
    chk("t4_vld_clr", m_vld, 0);

    // Stop mid-word with a pending word
    Dout_ready = 1'b0;
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0);
    bit_in(1'b1); bit_in(1'b1);
    Din_valid = 1'b0;
    chk("t5_cnt2", m_cnt, 2);
    Stop = 1'b1; tick(); Stop = 1'b0;
    chk("t5_stop_busy", m_busy, 0);
    chk("t5_stop_cnt", m_cnt, 0);
    chk("t5_pend_vld", m_vld, 1);
    chk("t5_pend_dout", m_dout, 4'h6);
    bit_in(1'b1); bit_in(1'b1); Din_valid = 1'b0;
    chk("t5_idle_cnt", m_cnt, 0);
    Dout_ready = 1'b1;
    tick();
    chk("t5_delivered", m_vld, 0);
    Start = 1'b1; Stop = 1'b1; tick(); Start = 1'b0; Stop = 1'b0;
    chk("t5_startstop_idle", m_busy, 0);
    pulse_start();
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    chk("t5_cnt3", m_cnt, 3);
    Din = 1'b1; Din_valid = 1'b1; Start = 1'b1; tick(); Start = 1'b0;
    chk("t5_restart_cnt", m_cnt, 0);
    chk("t5_restart_vld", m_vld, 0);
    chk("t5_restart_busy", m_busy, 1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b0); bit_in(1'b1);
    chk("t5_clean_dout", m_dout, 4'h9);
    chk("t5_clean_vld", m_vld, 1);
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    Stop = 1'b1; bit_in(1'b1); Stop = 1'b0; Din_valid = 1'b0;
    chk("t5_stopbit_vld", m_vld, 0);
    chk("t5_stopbit_dout", m_dout, 4'h9);
    chk("t5_stopbit_busy", m_busy, 0);

    // Asynchronous reset mid-word with a pending word
    Dout_ready = 1'b0;
    pulse_start();
    bit_in(1'b1); bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    Din_valid = 1'b0;
    chk("t6_pre_vld", m_vld, 1);
    chk("t6_pre_cnt", m_cnt, 3);
    #2 Rst_n = 1'b0;
    #1;
    chk("t6_dout", m_dout, 0);
    chk("t6_vld", m_vld, 0);
    chk("t6_busy", m_busy, 0);
    chk("t6_cnt", m_cnt, 0);
    chk("t6_lsb_dout", l_dout, 0);
    tick();
    Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) bit_in(1'b1);
    Din_valid = 1'b0;
    tick();
    chk("t6_post_vld", m_vld, 0);
    chk("t6_post_cnt", m_cnt, 0);
    chk("t6_post_busy", m_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_rx_ctrl.md
# sipo_rx_ctrl

Frame controller for the team's serial-in/parallel-out shift-register datapath. It sequences shifting of a qualified serial bit stream, counts bits into words of `WIDTH`, and moves each completed word into a holding register. The word is presented with a valid/ready handshake, and the block flags overrun when the consumer stalls. It sits between a serial source (pin sampler or bit-bang engine) and any parallel consumer.

## Interface

- `WIDTH`, default 4: bits per word; legal range 2..32.
- `MSB_FIRST`, default 1: when 1, the first received bit lands in `Dout[WIDTH-1]`. When 0, it lands in `Dout[0]`.
- `CW`, derived as `$clog2(WIDTH)`: width of the bit counter. Not user-overridable.

- `Clk` input 1: the only clock; rising-edge.
- `Rst_n` input 1: asynchronous, active-low reset.
- `Din` input 1: serial data bit.
- `Din_valid` input 1: `Din` is sampled on this edge.
- `Start` input 1: single-cycle pulse; begins or restarts a frame.
- `Stop` input 1: single-cycle pulse; ends the frame and discards any partial word.
- `Dout` output `WIDTH`: completed word from the holding register.
- `Dout_valid` output 1: `Dout` holds an undelivered word.
- `Dout_ready` input 1: the consumer accepts `Dout`.
- `Busy` output 1: the block is in state SHIFT.
- `Overrun` output 1: sticky; a completed word was dropped.
- `Bit_count` output `CW`: number of bits of the current partial word, 0..`WIDTH-1`.

## Operation

- **Internal registers:** shift register `sr[WIDTH-1:0]`, bit counter, 1-bit state (IDLE, SHIFT), holding register `Dout`, `Dout_valid`, `Overrun`.
- **Shift direction:**
  - `MSB_FIRST=1`: `sr <= {sr[WIDTH-2:0], Din}`.
  - `MSB_FIRST=0`: `sr <= {Din, sr[WIDTH-1:1]}`.
- **IDLE:**
  - `Din_valid` is ignored.
  - `Start` moves to SHIFT and clears `sr`, the counter and `Overrun`.
- **SHIFT:**
  - Each edge with `Din_valid`=1 shifts `Din` into `sr` and increments the counter.
  - The edge that accepts bit `WIDTH` ends the word:
    - the full word, including this bit, is written to the holding register if it is free;
    - the counter wraps to 0;
    - the state stays SHIFT, so words stream back-to-back.
  - `Start` restarts the frame: `sr`, the counter and `Overrun` are cleared, and a `Din_valid` in the same cycle is ignored.
  - `Stop` returns to IDLE and discards the partial word and counter. A pending `Dout`/`Dout_valid` is kept and remains deliverable.
- **Holding register handshake:**
  - A transfer occurs on an edge where `Dout_valid`=1 and `Dout_ready`=1. `Dout_valid` then clears, unless a new word completes on the same edge, in which case the new word loads and `Dout_valid` stays 1.
  - If a word completes while `Dout_valid`=1 and `Dout_ready`=0:
    - the new word is dropped;
    - `Dout` is unchanged;
    - `Overrun` is set.
  - `Overrun` clears only on `Start` or reset.
- **Simultaneous events:**
  - `Stop` with `Start`: `Stop` wins, next state IDLE.
  - `Stop` with a completing bit: `Stop` wins; the bit is discarded and no word is produced.
  - `Start` and `Stop` in IDLE: stay IDLE.
- **`Dout_ready`** is ignored while `Dout_valid`=0.

## Timing

- **Reset** (`Rst_n`=0, asynchronous, takes effect immediately):
  - state IDLE;
  - `sr`=0, `Dout`=0;
  - `Dout_valid`=0, `Busy`=0, `Overrun`=0, `Bit_count`=0.
- **Reset mid-frame:** loses the partial word and the pending word. After deassertion the block stays IDLE until `Start`.
- **`Busy`:** rises the cycle after the `Start` edge. It falls the cycle after the `Stop` edge.
- **Latency:** `Dout`/`Dout_valid` update on the same edge that accepts the final bit, so they are visible one cycle after the last `Din_valid` cycle.
- **Throughput:** one word per `WIDTH` cycles with `Din_valid` held high. No bubble between words.
- **`Bit_count`:** registered; shows bits accepted so far in the current word.
- **All outputs:** registered; no combinational path from inputs to outputs.

## Test plan

- **Basic MSB-first word.** Reset, `Start`, then bits 1,0,1,1 on four consecutive `Din_valid` cycles with `Dout_ready`=1 → `Dout`=4'b1011 and `Dout_valid`=1 for exactly one cycle, `Bit_count` sequence 1,2,3,0, `Busy`=1 throughout.
- **LSB-first with gaps.** `MSB_FIRST`=0; same bits 1,0,1,1 with `Din_valid` low for 2 cycles between bits → `Dout`=4'b1101; `Bit_count` holds during gaps.
- **Streaming and backpressure.** Send words 4'hA then 4'h5 back-to-back.
  - With `Dout_ready`=0 until after the second word completes → `Dout` stays 4'hA, `Overrun`=1.
  - Raising `Dout_ready` then clears `Dout_valid` after one transfer.
  - A following `Start` clears `Overrun`.
- **Transfer and completion on the same edge.** With `Dout_ready` high on the completing edge → `Dout_valid` stays 1, `Dout` takes the new word, `Overrun`=0.
- **Stop and Start mid-word.**
  - `Stop` after 2 bits → IDLE, `Bit_count`=0, no word; a pending word is still delivered.
  - `Start`+`Stop` in the same cycle → IDLE.
  - `Start` after 3 bits → the next 4 bits form a clean word.
- **Asynchronous reset mid-word.** Assert `Rst_n`=0 between clock edges after 3 bits → all outputs 0 immediately. `Din_valid` pulses before the next `Start` produce no word.
